// File: rtl/pb_debounce_pkg.sv
// Shared constants and helpers for the multi-channel push-button debouncer.
// The long-press option is enabled by defining PB_DEBOUNCE_LONG_PRESS_EN.
package pb_debounce_pkg;

  localparam int PB_SYNC_STAGES     = 2;
  localparam int PB_DEF_N_CH        = 4;
  localparam int PB_DEF_WIN         = 4;
  localparam int PB_DEF_SAMPLE_DIV  = 1;
  localparam int PB_DEF_HOLD_TICKS  = 1000;

  // Bits needed for a counter that must be able to hold max_val.
  function automatic int pb_cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pb_debounce_ch.sv
// One debounce channel: synchroniser, sample window, hysteretic level and edge pulses.
// Optional long-press hold counter built only when PB_DEBOUNCE_LONG_PRESS_EN is defined.
module pb_debounce_ch
  import pb_debounce_pkg::*;
#(
  parameter int WIN = PB_DEF_WIN
`ifdef PB_DEBOUNCE_LONG_PRESS_EN
  , parameter int HOLD_TICKS = PB_DEF_HOLD_TICKS
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic pb_raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic long_p
);

  logic [PB_SYNC_STAGES-1:0] sync_p0;
  logic [WIN-1:0]            win_p1;
  logic                      level_next;

  // Stage 0: metastability synchroniser, runs every clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[PB_SYNC_STAGES-2:0], pb_raw};
    end
  end

  // Stage 1: sample window, advances only on the shared tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_p1 <= '0;
    end else if (tick) begin
      win_p1 <= {win_p1[WIN-2:0], sync_p0[PB_SYNC_STAGES-1]};
    end
  end

  always_comb begin
    level_next = level;
    if (&win_p1) begin
      level_next = 1'b1;
    end else if (~|win_p1) begin
      level_next = 1'b0;
    end
  end

  // Stage 2: debounced level with pulses aligned to the first cycle of the new level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      level <= level_next;
      press <= ~level & level_next;
      rel   <= level & ~level_next;
    end
  end

`ifdef PB_DEBOUNCE_LONG_PRESS_EN
  localparam int              CW      = pb_cnt_w(HOLD_TICKS);
  localparam logic [CW-1:0]   HOLD    = CW'(HOLD_TICKS);
  localparam logic [CW-1:0]   HOLD_M1 = CW'(HOLD_TICKS - 1);

  logic [CW-1:0] hold_cnt;

  // Saturation at HOLD guarantees a single pulse per press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      long_p   <= 1'b0;
    end else begin
      long_p <= 1'b0;
      if (!level) begin
        hold_cnt <= '0;
      end else if (tick && (hold_cnt != HOLD)) begin
        hold_cnt <= hold_cnt + CW'(1);
        long_p   <= (hold_cnt == HOLD_M1);
      end
    end
  end
`else
  assign long_p = 1'b0;
`endif

endmodule

// File: rtl/pb_debounce_multi.sv
// N_CH-channel push-button debouncer sharing one sample-tick prescaler.
// Long-press pulses are available when PB_DEBOUNCE_LONG_PRESS_EN is defined.
module pb_debounce_multi
  import pb_debounce_pkg::*;
#(
  parameter int N_CH       = PB_DEF_N_CH,
  parameter int WIN        = PB_DEF_WIN,
  parameter int SAMPLE_DIV = PB_DEF_SAMPLE_DIV,
  parameter int HOLD_TICKS = PB_DEF_HOLD_TICKS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pb_in,
  output logic [N_CH-1:0] pb_level,
  output logic [N_CH-1:0] pb_press,
  output logic [N_CH-1:0] pb_release,
  output logic [N_CH-1:0] pb_long
);

  logic tick;

  generate
    if (N_CH < 1) begin : g_bad_nch
      $error("pb_debounce_multi: N_CH must be >= 1");
    end
    if (WIN < 2) begin : g_bad_win
      $error("pb_debounce_multi: WIN must be >= 2");
    end
    if (SAMPLE_DIV < 1) begin : g_bad_div
      $error("pb_debounce_multi: SAMPLE_DIV must be >= 1");
    end
    if (HOLD_TICKS < 1) begin : g_bad_hold
      $error("pb_debounce_multi: HOLD_TICKS must be >= 1");
    end
  endgenerate

  generate
    if (SAMPLE_DIV == 1) begin : g_no_div
      assign tick = 1'b1;
    end else begin : g_div
      localparam int            DW       = pb_cnt_w(SAMPLE_DIV - 1);
      localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

      logic [DW-1:0] div_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
      end

      assign tick = (div_cnt == DIV_LAST);
    end
  endgenerate

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      pb_debounce_ch #(
        .WIN        (WIN)
`ifdef PB_DEBOUNCE_LONG_PRESS_EN
        , .HOLD_TICKS (HOLD_TICKS)
`endif
      ) u_ch (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .pb_raw (pb_in[i]),
        .level  (pb_level[i]),
        .press  (pb_press[i]),
        .rel    (pb_release[i]),
        .long_p (pb_long[i])
      );
    end
  endgenerate

endmodule
